fmul_seq: RTL and testbench

Sequential IEEE-754 single-precision multiplier that answers the `start`/`valid_out` operation handshake used by the board-level operand loader and LED result display. It captures two FP32 operands on `start`, forms the 24×24 significand product with an iterative shift-add datapath, then normalises and rounds. It returns a held result plus a 5-bit exception vector. It sits beside the FP adder inside the floating-point ALU and is selected by op code.

---
 rtl/fmul_seq.sv | 253 +++++++++++++++++++++++++
 tb/tb_fmul_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_seq.sv
// fmul_seq: sequential IEEE-754 single-precision multiplier.
// Accepts two FP32 operands on start, forms the 24x24 significand product,
// normalises, rounds (RNE or RTZ) and holds the packed result plus flags.
// Subnormal inputs are flushed to zero; underflowing results flush to zero.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   start            - operation request, accepted only in IDLE
//   op_a, op_b       - FP32 operands, captured on accepted start
//   round_mode       - 0 = round-to-nearest-even, 1 = round-toward-zero
//   result           - FP32 product, held until the next accepted start
//   valid_out        - result/flags hold a completed operation
//   flags            - [4] invalid [3] div-by-zero (0) [2] overflow [1] underflow [0] inexact
//   busy             - operation in flight
//
// Build option: FMUL_FAST_MULT_EN selects a single-cycle combinational
// multiply (4-cycle latency) instead of the 24-cycle shift-add (27 cycles).
module fmul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        round_mode,
    output logic [31:0] result,
    output logic        valid_out,
    output logic [4:0]  flags,
    output logic        busy
);
    localparam int unsigned EXP_W  = 10;
    localparam int unsigned SIG_W  = 24;
    localparam int unsigned PROD_W = 48;
    localparam int unsigned CNT_W  = 5;
    localparam logic signed [EXP_W-1:0] EXP_BIAS = 10'sd127;
    localparam logic signed [EXP_W-1:0] EXP_MAX  = 10'sd255;
    localparam logic signed [EXP_W-1:0] EXP_MIN  = 10'sd1;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_MULT, S_NORM, S_ROUND
    } state_t;

    state_t state_q, state_d;

    logic [31:0]             a_q, a_d, b_q, b_d;
    logic                    rm_q, rm_d, sign_q, sign_d;
    logic signed [EXP_W-1:0] exp_q, exp_d;
    logic [SIG_W-1:0]        mcand_q, mcand_d, mplier_q, mplier_d;
    logic [PROD_W-1:0]       acc_q, acc_d;
    logic                    special_q, special_d;
    logic [31:0]             spec_res_q, spec_res_d;
    logic [4:0]              spec_flags_q, spec_flags_d;
    logic [31:0]             result_q, result_d;
    logic [4:0]              flags_q, flags_d;
    logic                    valid_q, valid_d, busy_q, busy_d;
`ifndef FMUL_FAST_MULT_EN
    logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

    // Operand classification (subnormals count as zero).
    logic a_max, b_max, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    assign a_max  = &a_q[30:23];
    assign b_max  = &b_q[30:23];
    assign a_zero = (a_q[30:23] == 8'd0);
    assign b_zero = (b_q[30:23] == 8'd0);
    assign a_nan  = a_max & (|a_q[22:0]);
    assign b_nan  = b_max & (|b_q[22:0]);
    assign a_inf  = a_max & ~(|a_q[22:0]);
    assign b_inf  = b_max & ~(|b_q[22:0]);
    assign a_snan = a_nan & ~a_q[22];
    assign b_snan = b_nan & ~b_q[22];

    // Rounding of the normalised product (MSB at bit 47).
    logic [SIG_W-1:0]        mant;
    logic                    g_bit, r_bit, s_bit, rnd_inc, inexact;
    logic [SIG_W:0]          mant_rnd;
    logic signed [EXP_W-1:0] exp_rnd;
    logic [22:0]             frac_rnd;
    assign mant     = acc_q[47:24];
    assign g_bit    = acc_q[23];
    assign r_bit    = acc_q[22];
    assign s_bit    = |acc_q[21:0];
    assign inexact  = g_bit | r_bit | s_bit;
    assign rnd_inc  = ~rm_q & g_bit & (r_bit | s_bit | mant[0]);
    assign mant_rnd = {1'b0, mant} + (SIG_W+1)'(rnd_inc);
    // A carry out means the significand became exactly 2.0.
    assign exp_rnd  = exp_q + (mant_rnd[SIG_W] ? 10'sd1 : 10'sd0);
    assign frac_rnd = mant_rnd[SIG_W] ? mant_rnd[23:1] : mant_rnd[22:0];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_UNPACK;
            S_UNPACK: state_d = S_MULT;
`ifdef FMUL_FAST_MULT_EN
            S_MULT:   state_d = S_NORM;
`else
            S_MULT:   if (cnt_q == CNT_W'(SIG_W-1)) state_d = S_NORM;
`endif
            S_NORM:   state_d = S_ROUND;
            S_ROUND:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        rm_d         = rm_q;
        sign_d       = sign_q;
        exp_d        = exp_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        acc_d        = acc_q;
        special_d    = special_q;
        spec_res_d   = spec_res_q;
        spec_flags_d = spec_flags_q;
        result_d     = result_q;
        flags_d      = flags_q;
        valid_d      = valid_q;
        busy_d       = busy_q;
`ifndef FMUL_FAST_MULT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    rm_d    = round_mode;
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_UNPACK: begin
                sign_d   = a_q[31] ^ b_q[31];
                exp_d    = $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]}) - EXP_BIAS;
                mcand_d  = {1'b1, a_q[22:0]};
                mplier_d = {1'b1, b_q[22:0]};
                acc_d    = '0;
`ifndef FMUL_FAST_MULT_EN
                cnt_d    = '0;
`endif
                // Specials in priority order: NaN, inf*0, inf, zero.
                special_d    = 1'b1;
                spec_flags_d = 5'b00000;
                if (a_nan | b_nan) begin
                    spec_res_d   = QNAN;
                    spec_flags_d = {a_snan | b_snan, 4'b0000};
                end else if ((a_inf & b_zero) | (a_zero & b_inf)) begin
                    spec_res_d   = QNAN;
                    spec_flags_d = 5'b10000;
                end else if (a_inf | b_inf) begin
                    spec_res_d   = {a_q[31] ^ b_q[31], 31'h7F800000};
                end else if (a_zero | b_zero) begin
                    spec_res_d   = {a_q[31] ^ b_q[31], 31'h00000000};
                end else begin
                    special_d    = 1'b0;
                    spec_res_d   = '0;
                end
            end
            S_MULT: begin
`ifdef FMUL_FAST_MULT_EN
                acc_d    = PROD_W'(mcand_q) * PROD_W'(mplier_q);
`else
                // One multiplier bit per cycle, weighted by the cycle index.
                acc_d    = acc_q + (mplier_q[0] ? (PROD_W'(mcand_q) << cnt_q) : '0);
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
`endif
            end
            S_NORM: begin
                if (acc_q[PROD_W-1]) exp_d = exp_q + 10'sd1;
                else                 acc_d = acc_q << 1;
            end
            S_ROUND: begin
                valid_d = 1'b1;
                busy_d  = 1'b0;
                if (special_q) begin
                    result_d = spec_res_q;
                    flags_d  = spec_flags_q;
                end else if (exp_rnd >= EXP_MAX) begin
                    result_d = rm_q ? {sign_q, 31'h7F7FFFFF} : {sign_q, 31'h7F800000};
                    flags_d  = 5'b00101;
                end else if (exp_rnd < EXP_MIN) begin
                    result_d = {sign_q, 31'h00000000};
                    flags_d  = 5'b00011;
                end else begin
                    result_d = {sign_q, exp_rnd[7:0], frac_rnd};
                    flags_d  = {4'b0000, inexact};
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            rm_q         <= 1'b0;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            special_q    <= 1'b0;
            spec_res_q   <= '0;
            spec_flags_q <= '0;
            result_q     <= '0;
            flags_q      <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
`ifndef FMUL_FAST_MULT_EN
            cnt_q        <= '0;
`endif
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            rm_q         <= rm_d;
            sign_q       <= sign_d;
            exp_q        <= exp_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            special_q    <= special_d;
            spec_res_q   <= spec_res_d;
            spec_flags_q <= spec_flags_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
`ifndef FMUL_FAST_MULT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign result    = result_q;
    assign flags     = flags_q;
    assign valid_out = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fmul_seq.sv
// tb_fmul_seq: scoreboard bench for fmul_seq.
// The driver pushes the expected product (from an arithmetic reference model)
// when a start is accepted; a negedge monitor pops and compares whenever
// valid_out rises, and also checks latency and that held outputs stay stable.
`timescale 1ns/1ps
module tb_fmul_seq;
`ifdef FMUL_FAST_MULT_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 27;
`endif

    logic        clk = 1'b0;
    logic        rst, start, round_mode;
    logic [31:0] op_a, op_b, result;
    logic [4:0]  flags;
    logic        valid_out, busy;

    always #5 clk = ~clk;

    fmul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .round_mode(round_mode),
        .result    (result),
        .valid_out (valid_out),
        .flags     (flags),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        int          t;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic        prev_v = 1'b0;
    logic [31:0] held_res = 32'h0;
    logic [4:0]  held_flg = 5'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact integer product, then divide down and round by remainder.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic rm,
                                  output logic [31:0] r, output logic [4:0] f);
        int     ea, eb, e, sh;
        longint ma, mb, p, q, rem, half;
        logic   s, an, bn, ai, bi, az, bz;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = longint'(a[22:0]);
        mb = longint'(b[22:0]);
        s  = a[31] ^ b[31];
        an = (ea == 255) && (ma != 0);
        bn = (eb == 255) && (mb != 0);
        ai = (ea == 255) && (ma == 0);
        bi = (eb == 255) && (mb == 0);
        az = (ea == 0);
        bz = (eb == 0);
        f  = 5'b00000;
        if (an || bn) begin
            r    = 32'h7FC00000;
            f[4] = (an && !a[22]) || (bn && !b[22]);
            return;
        end
        if ((ai && bz) || (az && bi)) begin
            r = 32'h7FC00000;
            f = 5'b10000;
            return;
        end
        if (ai || bi) begin
            r = {s, 31'h7F800000};
            return;
        end
        if (az || bz) begin
            r = {s, 31'h0};
            return;
        end
        p  = (ma + 64'd8388608) * (mb + 64'd8388608);
        e  = ea + eb - 127;
        sh = 23;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (!rm && ((rem > half) || ((rem == half) && q[0]))) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            r = rm ? {s, 31'h7F7FFFFF} : {s, 31'h7F800000};
            f = 5'b00101;
        end else if (e < 1) begin
            r = {s, 31'h0};
            f = 5'b00011;
        end else begin
            r    = {s, 8'(e), 23'(q)};
            f[0] = (rem != 0);
        end
    endfunction

    function automatic logic [31:0] gen_op();
        int k;
        k = $urandom_range(0, 13);
        case (k)
            0:  return 32'h00000000;
            1:  return 32'h80000000;
            2:  return 32'h7F800000;
            3:  return 32'hFF800000;
            4:  return {1'($urandom), 31'h7FC00000 | 31'($urandom_range(0, 1023))};
            5:  return {1'($urandom), 9'h1FF, 22'($urandom_range(1, 4194303))};
            6:  return {1'($urandom), 8'h00, 23'($urandom_range(1, 8388607))};
            7, 8, 9: return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
            default: return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    // Monitor: compare on every rising valid_out, check outputs hold while valid.
    always @(negedge clk) begin
        if (valid_out && !prev_v) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got %h with nothing expected", result);
            end else begin
                mon_e = sb.pop_front();
                check("result", result, mon_e.res);
                check("flags", 32'(flags), 32'(mon_e.flg));
                check("latency", 32'(cyc - mon_e.t), 32'(LAT));
            end
            held_res = result;
            held_flg = flags;
        end else if (valid_out && prev_v) begin
            check("held_result", result, held_res);
            check("held_flags", 32'(flags), 32'(held_flg));
        end
        prev_v = valid_out;
    end

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy && (w < 200)) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic rm);
        exp_t e;
        wait_idle();
        op_a       = a;
        op_b       = b;
        round_mode = rm;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        op_a       = $urandom;
        op_b       = $urandom;
        round_mode = 1'($urandom);
        model(a, b, rm, e.res, e.flg);
        e.t = cyc;
        sb.push_back(e);
        check("accept_valid_clear", 32'(valid_out), 32'd0);
        check("accept_busy", 32'(busy), 32'd1);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() != 0) && (w < 200)) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] dir_a [12];
    logic [31:0] dir_b [12];
    logic        dir_rm[12];
    int          pulse_at;

    initial begin
        dir_a = '{32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h7F000000,
                  32'h7F000000, 32'h00800000, 32'h7F800000, 32'h7F800001, 32'hFF800000, 32'h40400000};
        dir_b = '{32'h40000000, 32'h3F800001, 32'h3F800001, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h40000000,
                  32'h40000000, 32'h3F000000, 32'h80000000, 32'h3F800000, 32'h40000000, 32'hC0A00000};
        dir_rm = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; round_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, 32'h0);
        check("reset_flags", 32'(flags), 32'h0);
        check("reset_valid", 32'(valid_out), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);

        // Reset wins over a simultaneous start.
        start = 1'b1; op_a = 32'h3F800000; op_b = 32'h3F800000;
        @(posedge clk);
        #1;
        check("rst_start_busy", 32'(busy), 32'h0);
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors, back to back (each start lands while valid_out is high).
        for (int i = 0; i < 12; i++) issue(dir_a[i], dir_b[i], dir_rm[i]);
        drain();

        // A start while busy must be ignored.
        pulse_at = (LAT > 10) ? 10 : 2;
        issue(32'h40400000, 32'h40A00000, 1'b0);
        repeat (pulse_at - 1) @(posedge clk);
        #1;
        start = 1'b1; op_a = 32'h3F800000; op_b = 32'h3F800000;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ignored_start_busy", 32'(busy), 32'd1);
        drain();

        // Reset mid-operation aborts with no partial result.
        issue(32'h3FC00000, 32'h3FC00000, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(valid_out), 32'd0);
        check("abort_result", result, 32'h0);
        check("abort_flags", 32'(flags), 32'h0);
        issue(32'h3FC00000, 32'h3FC00000, 1'b0);
        drain();

        // Randomised vectors with occasional idle gaps.
        for (int i = 0; i < 120; i++) begin
            issue(gen_op(), gen_op(), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                wait_idle();
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
            end
        end
        drain();
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
